// File: rtl/toki_video_pkg.sv
`default_nettype none
// ============================================================================
// Module      : toki_video_pkg
// Description : Shared constants, FSM state type, tile-map entry layout and
//               line-buffer fill-pointer helpers for the BG layer renderers.
// Revision    : 1.0 - initial release
// ============================================================================
package toki_video_pkg;

    localparam int         TILE_W     = 16;
    localparam int         MAP_COLS   = 32;
    localparam logic [3:0] TRANSP_PIX = 4'hF;
    localparam int         LINE_W     = 256;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MAP  = 3'd1,
        ROM  = 3'd2,
        WR   = 3'd3,
        NEXT = 3'd4
    } bg_fsm_t;

    typedef struct packed {
        logic [3:0]  pal;
        logic [11:0] code;
    } tile_entry_t;

    // Unflipped lines fill left to right, so the pointer is one past the
    // rightmost write. Flipped lines fill right to left, so it is the
    // leftmost write and starts at 256 (nothing rendered).
    function automatic logic [8:0] fill_ptr_next(input logic [8:0] ptr,
                                                 input logic [7:0] addr,
                                                 input logic       flip);
        logic [8:0] a;
        a = {1'b0, addr};
        if (flip)
            return (a < ptr) ? a : ptr;
        else
            return ((a + 9'd1) > ptr) ? (a + 9'd1) : ptr;
    endfunction

    function automatic logic fill_hit(input logic [8:0] ptr,
                                      input logic [7:0] addr,
                                      input logic       flip);
        if (flip)
            return ({1'b0, addr} >= ptr);
        else
            return ({1'b0, addr} < ptr);
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_buf_2bank.sv
`default_nettype none
// ============================================================================
// Module      : line_buf_2bank
// Description : Two 256x8 line banks. Rendering writes the back bank while the
//               mixer reads the front bank. Per-bank fill pointers make any
//               pixel not yet rendered read as transparent.
// Revision    : 1.0 - initial release
// ============================================================================
module line_buf_2bank
    import toki_video_pkg::*;
#(
    parameter logic [3:0] TRANSP = 4'hF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_swap,
    input  logic       i_flip,
    input  logic       i_wr_en,
    input  logic [7:0] i_wr_addr,
    input  logic [7:0] i_wr_data,
    input  logic [7:0] i_rd_addr,
    output logic [7:0] o_rd_data
);

    localparam logic [7:0] c_EMPTY = {4'hF, TRANSP};

    logic [7:0] r_mem0 [0:255];
    logic [7:0] r_mem1 [0:255];
    logic       r_front;
    logic [8:0] r_ptr0;
    logic [8:0] r_ptr1;
    logic       r_flip0;
    logic       r_flip1;

    logic [8:0] w_front_ptr;
    logic       w_front_flip;
    logic [7:0] w_front_pix;

    // Pixel writes always land in the back bank (the one not selected as front).
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            if (r_front)
                r_mem0[i_wr_addr] <= i_wr_data;
            else
                r_mem1[i_wr_addr] <= i_wr_data;
        end
    end

    // Bank select and fill pointers; the bank leaving the front is cleared on swap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_front <= 1'b0;
            r_ptr0  <= 9'd0;
            r_ptr1  <= 9'd0;
            r_flip0 <= 1'b0;
            r_flip1 <= 1'b0;
        end else if (i_swap) begin
            r_front <= ~r_front;
            if (r_front) begin
                r_ptr1  <= i_flip ? 9'd256 : 9'd0;
                r_flip1 <= i_flip;
            end else begin
                r_ptr0  <= i_flip ? 9'd256 : 9'd0;
                r_flip0 <= i_flip;
            end
        end else if (i_wr_en) begin
            if (r_front)
                r_ptr0 <= fill_ptr_next(r_ptr0, i_wr_addr, r_flip0);
            else
                r_ptr1 <= fill_ptr_next(r_ptr1, i_wr_addr, r_flip1);
        end
    end

    // Select the front bank's data and fill state for the read address.
    always_comb begin
        w_front_ptr  = r_front ? r_ptr1  : r_ptr0;
        w_front_flip = r_front ? r_flip1 : r_flip0;
        w_front_pix  = r_front ? r_mem1[i_rd_addr] : r_mem0[i_rd_addr];
    end

    // Registered read with the transparent override for unrendered pixels.
    always_ff @(posedge clk) begin
        if (rst)
            o_rd_data <= c_EMPTY;
        else if (fill_hit(w_front_ptr, i_rd_addr, w_front_flip))
            o_rd_data <= w_front_pix;
        else
            o_rd_data <= c_EMPTY;
    end

endmodule
`default_nettype wire

// File: rtl/bg_tile_line_renderer.sv
`default_nettype none
// ============================================================================
// Module      : bg_tile_line_renderer
// Description : Scrolling 16x16-tile, 4bpp background line renderer for one
//               BG layer. Walks 17 tiles per line through the tile map and
//               gfx ROM and writes {palette,pixel} into a double-banked line
//               buffer read by the colour mixer.
//               Optional macro BG_FLIP_EN adds a 'flip' input that renders
//               the line vertically and horizontally mirrored.
// Revision    : 1.0 - initial release
// ============================================================================
module bg_tile_line_renderer
    import toki_video_pkg::*;
#(
    parameter logic [3:0] TRANSP = 4'hF,
    parameter int         LINE_W = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        line_start,
    input  logic [7:0]  line_number,
    input  logic [8:0]  scroll_x,
    input  logic [8:0]  scroll_y,
    output logic [9:0]  ram_addr,
    input  logic [15:0] ram_out,
    output logic [17:0] gfx_rom_addr,
    output logic        gfx_rom_cs,
    input  logic [15:0] gfx_rom_data,
    input  logic        gfx_rom_ok,
    input  logic [7:0]  line_buffer_addr,
    output logic [7:0]  line_buffer_out,
    output logic        busy
`ifdef BG_FLIP_EN
    ,
    input  logic        flip
`endif
);

    bg_fsm_t     r_state;
    logic [8:0]  r_y;
    logic [4:0]  r_colbase;
    logic [3:0]  r_fine;
    logic        r_flip;
    logic [4:0]  r_n;
    logic [1:0]  r_w;
    logic [1:0]  r_p;
    logic        r_map_ph;
    logic        r_fresh;
    tile_entry_t r_tile;
    logic [15:0] r_data;

    logic        w_flip;
    logic [8:0]  w_y;
    logic [9:0]  w_x;
    logic [15:0] w_shift;
    logic [4:0]  w_col_next;
    logic        w_wr_en;
    logic [7:0]  w_wr_addr;

`ifdef BG_FLIP_EN
    assign w_flip = flip;
`else
    assign w_flip = 1'b0;
`endif

    // Line geometry: source row, screen x of the current pixel, pixel nibble.
    always_comb begin
        w_y        = {1'b0, (w_flip ? ~line_number : line_number)} + scroll_y;
        w_x        = {1'b0, r_n, r_w, r_p} - {6'd0, r_fine};
        w_shift    = r_data << {r_p, 2'b00};
        w_col_next = r_colbase + r_n + 5'd1;
        w_wr_en    = (r_state == WR) && !line_start && (w_x < 10'(LINE_W));
        w_wr_addr  = r_flip ? ~w_x[7:0] : w_x[7:0];
    end

    // Render sequencer: map fetch, ROM word fetch, 4 pixel writes per word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_y          <= 9'd0;
            r_colbase    <= 5'd0;
            r_fine       <= 4'd0;
            r_flip       <= 1'b0;
            r_n          <= 5'd0;
            r_w          <= 2'd0;
            r_p          <= 2'd0;
            r_map_ph     <= 1'b0;
            r_fresh      <= 1'b0;
            r_tile       <= '0;
            r_data       <= 16'd0;
            ram_addr     <= 10'd0;
            gfx_rom_addr <= 18'd0;
            gfx_rom_cs   <= 1'b0;
            busy         <= 1'b0;
        end else if (line_start) begin
            // Restart from any state; an outstanding ROM request is abandoned.
            r_y        <= w_y;
            r_colbase  <= scroll_x[8:4];
            r_fine     <= scroll_x[3:0];
            r_flip     <= w_flip;
            r_n        <= 5'd0;
            r_w        <= 2'd0;
            r_p        <= 2'd0;
            r_map_ph   <= 1'b0;
            r_fresh    <= 1'b0;
            ram_addr   <= {w_y[8:4], scroll_x[8:4]};
            gfx_rom_cs <= 1'b0;
            busy       <= 1'b1;
            r_state    <= MAP;
        end else begin
            case (r_state)
                IDLE: ;
                MAP: begin
                    // First cycle lets the RAM register the address.
                    if (!r_map_ph) begin
                        r_map_ph <= 1'b1;
                    end else begin
                        r_map_ph     <= 1'b0;
                        r_tile       <= tile_entry_t'(ram_out);
                        gfx_rom_addr <= {ram_out[11:0], r_y[3:0], 2'd0};
                        gfx_rom_cs   <= 1'b1;
                        r_fresh      <= 1'b1;
                        r_w          <= 2'd0;
                        r_state      <= ROM;
                    end
                end
                ROM: begin
                    // ok in the cycle right after an address change belongs
                    // to the previous address and is ignored.
                    if (r_fresh) begin
                        r_fresh <= 1'b0;
                    end else if (gfx_rom_ok) begin
                        r_data     <= gfx_rom_data;
                        gfx_rom_cs <= 1'b0;
                        r_p        <= 2'd0;
                        r_state    <= WR;
                    end
                end
                WR: begin
                    r_p <= r_p + 2'd1;
                    if (r_p == 2'd3)
                        r_state <= NEXT;
                end
                NEXT: begin
                    if (r_w == 2'd3) begin
                        if (r_n == 5'd16) begin
                            busy    <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_n      <= r_n + 5'd1;
                            ram_addr <= {r_y[8:4], w_col_next};
                            r_map_ph <= 1'b0;
                            r_state  <= MAP;
                        end
                    end else begin
                        r_w          <= r_w + 2'd1;
                        gfx_rom_addr <= {r_tile.code, r_y[3:0], r_w + 2'd1};
                        gfx_rom_cs   <= 1'b1;
                        r_fresh      <= 1'b1;
                        r_state      <= ROM;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    line_buf_2bank #(
        .TRANSP (TRANSP)
    ) u_line_buf (
        .clk       (clk),
        .rst       (rst),
        .i_swap    (line_start),
        .i_flip    (w_flip),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data ({r_tile.pal, w_shift[15:12]}),
        .i_rd_addr (line_buffer_addr),
        .o_rd_data (line_buffer_out)
    );

endmodule
`default_nettype wire

// File: tb/tb_bg_tile_line_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bg_tile_line_renderer
// Description : Self-checking bench for bg_tile_line_renderer. A screen-space
//               line model predicts each bank; a sweep process compares the
//               front bank every cycle. Define BG_FLIP_EN for the flip case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bg_tile_line_renderer;

    logic        clk = 1'b0;
    logic        rst;
    logic        line_start;
    logic [7:0]  line_number;
    logic [8:0]  scroll_x;
    logic [8:0]  scroll_y;
    logic [9:0]  ram_addr;
    logic [15:0] ram_out;
    logic [17:0] gfx_rom_addr;
    logic        gfx_rom_cs;
    logic [15:0] gfx_rom_data;
    logic        gfx_rom_ok;
    logic [7:0]  line_buffer_addr;
    logic [7:0]  line_buffer_out;
    logic        busy;
`ifdef BG_FLIP_EN
    logic        flip_in = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    logic [15:0] map_mem [0:1023];
    logic [7:0]  front_exp [0:255];
    logic [7:0]  back_exp  [0:255];

    bit          rom_const = 1'b0;
    int          rom_mode  = 0;
    bit          stall_on  = 1'b0;
    int          stall_base = 0;
    int          chg_cnt   = 0;
    int          age       = 0;
    logic [17:0] last_rom_a = 18'd0;

    bit          chk_on = 1'b0;
    bit          pend_v = 1'b0;
    logic [7:0]  pend_a = 8'd0;
    logic [7:0]  pend_exp = 8'hFF;
    logic [7:0]  rd_a = 8'hFF;

    bg_tile_line_renderer #(.TRANSP(4'hF), .LINE_W(256)) dut (
        .clk              (clk),
        .rst              (rst),
        .line_start       (line_start),
        .line_number      (line_number),
        .scroll_x         (scroll_x),
        .scroll_y         (scroll_y),
        .ram_addr         (ram_addr),
        .ram_out          (ram_out),
        .gfx_rom_addr     (gfx_rom_addr),
        .gfx_rom_cs       (gfx_rom_cs),
        .gfx_rom_data     (gfx_rom_data),
        .gfx_rom_ok       (gfx_rom_ok),
        .line_buffer_addr (line_buffer_addr),
        .line_buffer_out  (line_buffer_out),
        .busy             (busy)
`ifdef BG_FLIP_EN
        ,
        .flip             (flip_in)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_word(input logic [17:0] a);
        logic [31:0] t;
        if (rom_const) return 16'h0123;
        t = ({14'd0, a} * 32'h0000_9E37) ^ ({14'd0, a} >> 3);
        return t[15:0];
    endfunction

    // Screen-space model: for every screen x find the tile pixel that covers it.
    task automatic model_line(input int ln, input int sx, input int sy, input bit fl, input int ntiles);
        int yy, tx, n, p, col, dst;
        logic [15:0] e, wd, sh;
        logic [17:0] ra;
        yy = ((fl ? 255 - ln : ln) + sy) % 512;
        for (int x = 0; x < 256; x++) begin
            tx  = x + (sx % 16);
            n   = tx / 16;
            p   = tx % 16;
            col = (sx / 16 + n) % 32;
            e   = map_mem[(yy / 16) * 32 + col];
            ra  = 18'(e[11:0] * 64 + (yy % 16) * 4 + p / 4);
            wd  = rom_word(ra);
            sh  = wd >> (12 - 4 * (p % 4));
            dst = fl ? 255 - x : x;
            back_exp[dst] = (n < ntiles) ? {e[15:12], sh[3:0]} : 8'hFF;
        end
    endtask

    // Tile-map RAM with one cycle of read latency.
    always @(posedge clk) ram_out <= map_mem[ram_addr];

    // gfx ROM: stale data in the cycle after an address change, ok per mode.
    always @(negedge clk) begin
        if (gfx_rom_addr !== last_rom_a) begin
            age = 0;
            chg_cnt = chg_cnt + 1;
            last_rom_a = gfx_rom_addr;
        end else if (age < 1000) begin
            age = age + 1;
        end
        gfx_rom_data = (age == 0) ? ~rom_word(gfx_rom_addr) : rom_word(gfx_rom_addr);
        case (rom_mode)
            1:       gfx_rom_ok = !(stall_on && (chg_cnt - stall_base >= 13));
            2:       gfx_rom_ok = (age == 0) || (age >= 3);
            default: gfx_rom_ok = 1'b1;
        endcase
    end

    // The front model follows the DUT's bank swap.
    always @(posedge clk) begin
        if (!rst && line_start)
            for (int i = 0; i < 256; i++) front_exp[i] <= back_exp[i];
    end

    // Read sweep: compare the previous cycle's read, then issue the next one.
    always @(negedge clk) begin
        if (chk_on && pend_v) begin
            total = total + 1;
            if (line_buffer_out !== pend_exp) begin
                bad = bad + 1;
                $display("FAIL lb_sweep x=%0d got=%h exp=%h t=%0t", pend_a, line_buffer_out, pend_exp, $time);
            end
        end
        rd_a = rd_a + 8'd1;
        line_buffer_addr = rd_a;
        pend_a   = rd_a;
        pend_exp = front_exp[rd_a];
        pend_v   = 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Wait for the sweep to present address x, then check the literal value.
    task automatic check_rd(input string nm, input int x, input logic [7:0] exp);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < 600 && !hit; k++) begin
            @(posedge clk);
            #1;
            if (pend_a == 8'(x)) hit = 1'b1;
        end
        total = total + 1;
        if (!hit || line_buffer_out !== exp) begin
            bad = bad + 1;
            $display("FAIL %s x=%0d got=%h exp=%h reached=%0d", nm, x, line_buffer_out, exp, hit);
        end
    endtask

    task automatic wait_cs(input string nm);
        for (int k = 0; k < 50 && gfx_rom_cs !== 1'b1; k++) @(negedge clk);
        chk(nm, {31'd0, gfx_rom_cs}, 32'd1);
    endtask

    task automatic wait_idle(input string nm);
        for (int k = 0; k < 4000 && busy !== 1'b0; k++) @(negedge clk);
        chk(nm, {31'd0, busy}, 32'd0);
    endtask

    task automatic start_line(input int ln, input int sx, input int sy, input bit fl, input int mode);
        @(negedge clk);
        line_number = 8'(ln);
        scroll_x    = 9'(sx);
        scroll_y    = 9'(sy);
`ifdef BG_FLIP_EN
        flip_in     = fl;
`endif
        rom_mode    = mode;
        stall_on    = 1'b0;
        stall_base  = chg_cnt;
        line_start  = 1'b1;
        @(negedge clk);
        line_start  = 1'b0;
        model_line(ln, sx, sy, fl, 17);
    endtask

    logic [15:0] t3_e;
    logic [15:0] t3_w;

    initial begin
        rst = 1'b1; line_start = 1'b0; line_number = 8'd0;
        scroll_x = 9'd0; scroll_y = 9'd0;
        for (int i = 0; i < 256; i++) begin front_exp[i] = 8'hFF; back_exp[i] = 8'hFF; end
        for (int i = 0; i < 1024; i++) map_mem[i] = 16'(i * 16'h2B71 + 16'h1357);
        map_mem[0] = 16'h3005;
`ifdef BG_FLIP_EN
        map_mem[480] = 16'h3005;
`endif
        // Reset, with a line_start pulse that must be ignored.
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        @(negedge clk);
        chk("rst_cs", {31'd0, gfx_rom_cs}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ram_addr", {22'd0, ram_addr}, 32'd0);
        chk("rst_rom_addr", {14'd0, gfx_rom_addr}, 32'd0);
        chk("rst_lb_out", {24'd0, line_buffer_out}, 32'hFF);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("ls_in_reset_ignored", {31'd0, busy}, 32'd0);
        check_rd("unrendered_read", 77, 8'hFF);

        // Line 0, no scroll, constant ROM word.
        rom_const = 1'b1;
        start_line(0, 0, 0, 1'b0, 0);
        wait_cs("a_cs");
        chk("a_first_rom_addr", {14'd0, gfx_rom_addr}, 32'h00140);
        wait_idle("a_done");

        // Negative-ish scroll wrap; line A becomes front.
        rom_const = 1'b0;
        start_line(10, 9'h1FB, 9'h1F8, 1'b0, 0);
        chk("b_first_map_addr", {22'd0, ram_addr}, 32'h01F);
        wait_cs("b_cs");
        chk("b_pix_row", {28'd0, gfx_rom_addr[5:2]}, 32'd2);
        check_rd("a_x0", 0, 8'h30);
        check_rd("a_x1", 1, 8'h31);
        check_rd("a_x2", 2, 8'h32);
        check_rd("a_x3", 3, 8'h33);
        wait_idle("b_done");
        t3_e = map_mem[31];
        t3_w = rom_word({t3_e[11:0], 4'h2, 2'd2});

        // Stall inside tile 3, then abort with a new line (B becomes front).
        @(negedge clk);
        start_line(20, 9'h025, 0, 1'b0, 1);
        stall_on = 1'b1;
        check_rd("b_x0_tile0_pix11", 0, {t3_e[15:12], t3_w[3:0]});
        repeat (300) @(negedge clk);
        chk("c_stalled_cs", {31'd0, gfx_rom_cs}, 32'd1);
        chk("c_stalled_busy", {31'd0, busy}, 32'd1);
        model_line(20, 9'h025, 0, 1'b0, 3);

        // Restart; ok only in the address-change cycle, then after a delay.
        start_line(100, 9'h0A7, 9'h133, 1'b0, 2);
        chk("abort_cs_drop", {31'd0, gfx_rom_cs}, 32'd0);
        chk("abort_restart_map", {22'd0, ram_addr}, 32'h32A);
        chk("abort_busy", {31'd0, busy}, 32'd1);
        check_rd("c_partial_edge", 43, 8'hFF);
        wait_idle("d_done");

`ifdef BG_FLIP_EN
        rom_const = 1'b1;
        start_line(0, 0, 0, 1'b1, 0);
        wait_cs("e_cs");
        chk("e_flip_rom_addr", {14'd0, gfx_rom_addr}, 32'h0017C);
        wait_idle("e_done");
        rom_const = 1'b0;
`endif

        // Final swap exposes the last render to the sweep.
        start_line(30, 9'h040, 9'h010, 1'b0, 0);
`ifdef BG_FLIP_EN
        check_rd("e_x252", 252, 8'h33);
        check_rd("e_x253", 253, 8'h32);
        check_rd("e_x254", 254, 8'h31);
        check_rd("e_x255", 255, 8'h30);
`endif
        repeat (300) @(negedge clk);
        wait_idle("f_done");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
